// File: rtl/spi_target_responder.sv
// SPI mode-0 target: oversamples cs/sclk/din in ref_clk, shifts 8-bit bytes MSB first,
// and serves transmit bytes from a one-deep holding buffer written by the host.
module spi_target_responder (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk,
  input  logic       din,
  output logic       dout,
  input  logic       tx_wr,
  input  logic [7:0] TX_DATA,
  output logic       tx_full,
  output logic [7:0] RX_DATA,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [2:0] cs_sync_q, cs_sync_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] din_sync_q, din_sync_d;
  logic [1:0] settle_q, settle_d;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sreg_q, rx_sreg_d;
  logic [6:0] tx_sreg_q, tx_sreg_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_full_q, tx_full_d;
  logic       dout_q, dout_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       tx_underrun_q, tx_underrun_d;

  logic       settled;
  logic       cs_fall, cs_rise, sclk_rise;
  logic       load_req;
  logic [7:0] load_byte;
  logic [7:0] rx_byte;

  // The third sync stage still holds its reset value for three cycles after reset
  // release; events are masked until then so a cs already low is not taken as a fall.
  assign settled   = (settle_q == 2'd3);
  assign cs_fall   = settled &  cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise   = settled & ~cs_sync_q[2] &  cs_sync_q[1];
  assign sclk_rise = settled & ~sclk_sync_q[2] & sclk_sync_q[1];

  always_comb begin
    cs_sync_d     = {cs_sync_q[1:0], cs};
    sclk_sync_d   = {sclk_sync_q[1:0], sclk};
    din_sync_d    = {din_sync_q[0], din};
    settle_d      = settled ? settle_q : settle_q + 2'd1;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sreg_d     = rx_sreg_q;
    tx_sreg_d     = tx_sreg_q;
    hold_d        = hold_q;
    tx_full_d     = tx_full_q;
    dout_d        = dout_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    tx_underrun_d = 1'b0;
    load_req      = 1'b0;
    load_byte     = 8'h00;
    rx_byte       = {rx_sreg_q, din_sync_q[1]};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          load_req  = 1'b1;
          bit_cnt_d = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_sreg_d = rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            bit_cnt_d  = 3'd0;
            load_req   = 1'b1;
          end else begin
            // dout_q already shows the current MSB; tx_sreg holds only the bits still to go.
            bit_cnt_d = bit_cnt_q + 3'd1;
            dout_d    = tx_sreg_q[6];
            tx_sreg_d = {tx_sreg_q[5:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_req) begin
      if (tx_full_q) begin
        load_byte = hold_q;
        tx_full_d = 1'b0;
      end else begin
        tx_underrun_d = 1'b1;
      end
      dout_d    = load_byte[7];
      tx_sreg_d = load_byte[6:0];
    end

    // The sclk bit has been applied above, so a byte completed on this cycle is not an error.
    if (state_q == SHIFT && cs_rise) begin
      state_d = IDLE;
      dout_d  = 1'b0;
      if (bit_cnt_d != 3'd0) begin
        frame_err_d = 1'b1;
      end
    end

    if (tx_wr) begin
      hold_d    = TX_DATA;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q     <= 3'b111;
      sclk_sync_q   <= 3'b000;
      din_sync_q    <= 2'b00;
      settle_q      <= 2'd0;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_sreg_q     <= 7'h00;
      tx_sreg_q     <= 7'h00;
      hold_q        <= 8'h00;
      tx_full_q     <= 1'b0;
      dout_q        <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      din_sync_q    <= din_sync_d;
      settle_q      <= settle_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sreg_q     <= rx_sreg_d;
      tx_sreg_q     <= tx_sreg_d;
      hold_q        <= hold_d;
      tx_full_q     <= tx_full_d;
      dout_q        <= dout_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign dout        = dout_q;
  assign tx_full     = tx_full_q;
  assign RX_DATA     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_target_responder.sv
// Bench for spi_target_responder: a bit-banged SPI master with received bytes
// checked against a scoreboard queue as rx_valid pulses arrive.
module tb_spi_target_responder;

  logic       ref_clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       sclk;
  logic       din;
  logic       dout;
  logic       tx_wr;
  logic [7:0] TX_DATA;
  logic       tx_full;
  logic [7:0] RX_DATA;
  logic       rx_valid;
  logic       frame_err;
  logic       tx_underrun;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;
  int rx_cnt = 0;
  int ferr_cnt = 0;
  int urun_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] mon_exp;

  always #5 ref_clk = ~ref_clk;

  spi_target_responder dut (
    .ref_clk    (ref_clk),
    .reset      (reset),
    .cs         (cs),
    .sclk       (sclk),
    .din        (din),
    .dout       (dout),
    .tx_wr      (tx_wr),
    .TX_DATA    (TX_DATA),
    .tx_full    (tx_full),
    .RX_DATA    (RX_DATA),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  // Scoreboard side: every received byte is matched against the oldest expected one.
  always @(negedge ref_clk) begin
    if (rx_valid) begin
      rx_cnt++;
      tests_run++;
      if (exp_rx.size() == 0) begin
        tests_failed++;
        $display("FAIL rx_unexpected: got RX_DATA=%02h, no byte expected", RX_DATA);
      end else begin
        mon_exp = exp_rx.pop_front();
        if (RX_DATA !== mon_exp) begin
          tests_failed++;
          $display("FAIL rx_data: got %02h, expected %02h", RX_DATA, mon_exp);
        end else begin
          $display("[TB] rx byte %02h", RX_DATA);
        end
      end
    end
    if (frame_err)   ferr_cnt++;
    if (tx_underrun) urun_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic tx_write(input logic [7:0] b);
    tx_wr   = 1'b1;
    TX_DATA = b;
    @(negedge ref_clk);
    tx_wr   = 1'b0;
  endtask

  // Master sample point is the end of the low phase, just before the rising edge.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      din = mosi[7-i];
      wait_clk(6);
      miso[7-i] = dout;
      sclk = 1'b1;
      wait_clk(6);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso);
    exp_rx.push_back(mosi);
    spi_bits(mosi, 8, miso);
    $display("[TB] spi byte mosi=%02h miso=%02h", mosi, miso);
  endtask

  task automatic cs_end();
    wait_clk(3);
    cs = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 1'b1; sclk = 1'b0; din = 1'b0; tx_wr = 1'b0; TX_DATA = 8'h00;
    wait_clk(3);
    tests_run++; if (dout !== 1'b0)     begin tests_failed++; $display("FAIL reset_dout: got %b, expected 0", dout); end
    tests_run++; if (RX_DATA !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %02h, expected 00", RX_DATA); end
    tests_run++; if ({rx_valid, frame_err, tx_underrun} !== 3'b000)
      begin tests_failed++; $display("FAIL reset_pulses: got %b, expected 000", {rx_valid, frame_err, tx_underrun}); end
    tests_run++; if (tx_full !== 1'b0)  begin tests_failed++; $display("FAIL reset_tx_full: got %b, expected 0", tx_full); end
    tests_run++; if (busy !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    reset = 1'b1;
    wait_clk(6);
    $display("[TB] reset released");
  endtask

  task automatic test_single_byte();
    logic [7:0] m;
    int r0, f0;
    r0 = rx_cnt; f0 = ferr_cnt;
    tx_write(8'hA5);
    tests_run++; if (tx_full !== 1'b1) begin tests_failed++; $display("FAIL single_full_set: got %b, expected 1", tx_full); end
    cs = 1'b0;
    wait_clk(5);
    tests_run++; if (tx_full !== 1'b0) begin tests_failed++; $display("FAIL single_full_clr: got %b, expected 0", tx_full); end
    tests_run++; if (busy !== 1'b1)    begin tests_failed++; $display("FAIL single_busy: got %b, expected 1", busy); end
    spi_byte(8'h3C, m);
    cs_end();
    tests_run++; if (m !== 8'hA5)         begin tests_failed++; $display("FAIL single_miso: got %02h, expected A5", m); end
    tests_run++; if (rx_cnt - r0 !== 1)   begin tests_failed++; $display("FAIL single_rx_count: got %0d, expected 1", rx_cnt - r0); end
    tests_run++; if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL single_frame_err: got %0d, expected 0", ferr_cnt - f0); end
    tests_run++; if (RX_DATA !== 8'h3C)   begin tests_failed++; $display("FAIL single_rx_data: got %02h, expected 3C", RX_DATA); end
    tests_run++; if ({busy, dout} !== 2'b00) begin tests_failed++; $display("FAIL single_idle: got busy,dout=%b, expected 00", {busy, dout}); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] m0, m1;
    int r0;
    r0 = rx_cnt;
    tx_write(8'h12);
    cs = 1'b0;
    wait_clk(5);
    tx_write(8'h34);
    tests_run++; if (tx_full !== 1'b1) begin tests_failed++; $display("FAIL multi_full: got %b, expected 1", tx_full); end
    spi_byte(8'hF0, m0);
    spi_byte(8'h0F, m1);
    cs_end();
    tests_run++; if (m0 !== 8'h12)       begin tests_failed++; $display("FAIL multi_miso0: got %02h, expected 12", m0); end
    tests_run++; if (m1 !== 8'h34)       begin tests_failed++; $display("FAIL multi_miso1: got %02h, expected 34", m1); end
    tests_run++; if (rx_cnt - r0 !== 2)  begin tests_failed++; $display("FAIL multi_rx_count: got %0d, expected 2", rx_cnt - r0); end
    tests_run++; if (RX_DATA !== 8'h0F)  begin tests_failed++; $display("FAIL multi_rx_data: got %02h, expected 0F", RX_DATA); end
  endtask

  task automatic test_underrun();
    logic [7:0] m;
    int u0;
    u0 = urun_cnt;
    cs = 1'b0;
    wait_clk(5);
    tests_run++; if (urun_cnt - u0 !== 1) begin tests_failed++; $display("FAIL underrun_pulse: got %0d, expected 1", urun_cnt - u0); end
    spi_byte(8'hC3, m);
    cs_end();
    tests_run++; if (m !== 8'h00)       begin tests_failed++; $display("FAIL underrun_miso: got %02h, expected 00", m); end
    tests_run++; if (RX_DATA !== 8'hC3) begin tests_failed++; $display("FAIL underrun_rx_data: got %02h, expected C3", RX_DATA); end
  endtask

  task automatic test_abort();
    logic [7:0] m;
    int f0, r0;
    f0 = ferr_cnt; r0 = rx_cnt;
    cs = 1'b0;
    spi_bits(8'hFF, 5, m);
    cs_end();
    $display("[TB] aborted frame after 5 bits");
    tests_run++; if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL abort_frame_err: got %0d, expected 1", ferr_cnt - f0); end
    tests_run++; if (rx_cnt - r0 !== 0)   begin tests_failed++; $display("FAIL abort_rx_count: got %0d, expected 0", rx_cnt - r0); end
    tests_run++; if (RX_DATA !== 8'hC3)   begin tests_failed++; $display("FAIL abort_rx_kept: got %02h, expected C3", RX_DATA); end
    tests_run++; if ({busy, dout} !== 2'b00) begin tests_failed++; $display("FAIL abort_idle: got busy,dout=%b, expected 00", {busy, dout}); end
    cs = 1'b0;
    spi_byte(8'h81, m);
    cs_end();
    tests_run++; if (RX_DATA !== 8'h81)   begin tests_failed++; $display("FAIL abort_followup: got %02h, expected 81", RX_DATA); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] m;
    int r0, f0;
    tx_write(8'h5A);
    cs = 1'b0;
    spi_bits(8'hAA, 4, m);
    reset = 1'b0;
    wait_clk(2);
    tests_run++; if ({busy, tx_full, dout} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_state: got busy,full,dout=%b, expected 000", {busy, tx_full, dout}); end
    tests_run++; if (RX_DATA !== 8'h00) begin tests_failed++; $display("FAIL rstmid_rx_data: got %02h, expected 00", RX_DATA); end
    reset = 1'b1;
    r0 = rx_cnt; f0 = ferr_cnt;
    wait_clk(2);
    spi_bits(8'hAA, 4, m);
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL rstmid_no_restart: got busy=%b, expected 0", busy); end
    cs_end();
    $display("[TB] reset mid-frame done");
    tests_run++; if (rx_cnt - r0 !== 0)   begin tests_failed++; $display("FAIL rstmid_rx_count: got %0d, expected 0", rx_cnt - r0); end
    tests_run++; if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL rstmid_frame_err: got %0d, expected 0", ferr_cnt - f0); end
    cs = 1'b0;
    spi_byte(8'h55, m);
    cs_end();
    tests_run++; if (RX_DATA !== 8'h55)   begin tests_failed++; $display("FAIL rstmid_new_frame: got %02h, expected 55", RX_DATA); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] m0, m1;
    tx_write(8'h77);
    cs = 1'b0;
    // cs_fall is seen after the second rising edge; the load registers on the third.
    wait_clk(2);
    tx_write(8'h99);
    tests_run++; if (tx_full !== 1'b1) begin tests_failed++; $display("FAIL simul_full: got %b, expected 1", tx_full); end
    tests_run++; if (busy !== 1'b1)    begin tests_failed++; $display("FAIL simul_busy: got %b, expected 1", busy); end
    spi_byte(8'h11, m0);
    spi_byte(8'h22, m1);
    cs_end();
    tests_run++; if (m0 !== 8'h77)     begin tests_failed++; $display("FAIL simul_miso0: got %02h, expected 77", m0); end
    tests_run++; if (m1 !== 8'h99)     begin tests_failed++; $display("FAIL simul_miso1: got %02h, expected 99", m1); end
    tests_run++; if (tx_full !== 1'b0) begin tests_failed++; $display("FAIL simul_full_end: got %b, expected 0", tx_full); end
  endtask

  initial begin
    @(negedge ref_clk);
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_simultaneous();
    wait_clk(4);
    tests_run++;
    if (exp_rx.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d bytes pending, expected 0", exp_rx.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
